// File: rtl/gcd_arbiter.sv
// gcd_arbiter
//   Shares one four-phase GCD unit between two four-phase clients.
//   A transaction is two handshakes on the same request line: operand A,
//   then operand B with the result returned on the second acknowledge.
//   The grant is held for the whole transaction; ties between clients
//   are broken round-robin, with client 0 winning the first tie after reset.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   req0/req1      client requests (four-phase)
//   AB0/AB1        client operand buses (A first, then B)
//   ack0/ack1      client acknowledges (A accepted / result valid)
//   C0/C1          client results, non-zero only while the result is valid
//   gcd_req        request to the shared GCD unit
//   gcd_AB         operand to the shared GCD unit
//   gcd_ack        acknowledge from the shared GCD unit
//   gcd_C          result from the shared GCD unit (may float outside its result phase)
//   busy           a client currently holds the grant
//   grant          index of the granted client, meaningful while busy
module gcd_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] AB0,
  output logic              ack0,
  output logic [DATA_W-1:0] C0,
  input  logic              req1,
  input  logic [DATA_W-1:0] AB1,
  output logic              ack1,
  output logic [DATA_W-1:0] C1,
  output logic              gcd_req,
  output logic [DATA_W-1:0] gcd_AB,
  input  logic              gcd_ack,
  input  logic [DATA_W-1:0] gcd_C,
  output logic              busy,
  output logic              grant
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] A_PH   = 3'd1;
  localparam logic [2:0] A_REL  = 3'd2;
  localparam logic [2:0] B_WAIT = 3'd3;
  localparam logic [2:0] B_PH   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       grant_r;
  logic       grant_nxt;
  logic       last_r;
  logic       last_nxt;
  logic       req_g;

  // Request line of whichever client currently owns the GCD unit.
  assign req_g = grant_r ? req1 : req0;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_r;
    last_nxt  = last_r;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt = A_PH;
          // On a tie the client that was not served last wins; otherwise
          // the single requester wins.
          if (req0 && req1) grant_nxt = ~last_r;
          else              grant_nxt = req1;
        end
      end
      A_PH:   if (gcd_ack)             state_nxt = A_REL;
      A_REL:  if (!req_g && !gcd_ack)  state_nxt = B_WAIT;
      B_WAIT: if (req_g)               state_nxt = B_PH;
      B_PH:   if (gcd_ack)             state_nxt = DONE;
      DONE: begin
        if (!req_g) begin
          state_nxt = IDLE;
          last_nxt  = grant_r;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant_r <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      state   <= state_nxt;
      grant_r <= grant_nxt;
      last_r  <= last_nxt;
    end
  end

  // Only legal transaction states count as busy, so a corrupted state
  // encoding never routes a client onto the GCD unit before it recovers.
  assign busy  = (state == A_PH) || (state == A_REL) || (state == B_WAIT) ||
                 (state == B_PH) || (state == DONE);
  assign grant = grant_r;

  // Pure combinational routing: no added latency on any handshake path.
  always_comb begin
    gcd_req = 1'b0;
    gcd_AB  = '0;
    ack0    = 1'b0;
    ack1    = 1'b0;
    C0      = '0;
    C1      = '0;
    if (busy) begin
      gcd_req = req_g;
      gcd_AB  = grant_r ? AB1 : AB0;
      if (grant_r) ack1 = gcd_ack;
      else         ack0 = gcd_ack;
      // The result bus is only trusted in the result phase; elsewhere the
      // GCD unit may leave it floating, so clients see zero instead.
      if ((state == DONE) && gcd_ack) begin
        if (grant_r) C1 = gcd_C;
        else         C0 = gcd_C;
      end
    end
  end

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: req0  input  1  client 0 request, four-phase, operand A then operand B.
REQ-004 SHALL have port: AB0  input  16  client 0 operand bus, one operand per request phase.
REQ-005 SHALL have port: ack0  output  1  client 0 acknowledge: A accepted, or result valid.
REQ-006 SHALL have port: C0  output  16  client 0 result; valid while ack0 is high in the result phase.
REQ-007 SHALL have ports req1, AB1, ack1, C1, identical in direction, width and meaning to the client 0 ports, for client 1.
REQ-008 SHALL have port: gcd_req  output  1  request to the shared GCD unit.
REQ-009 SHALL have port: gcd_AB  output  16  operand to the shared GCD unit.
REQ-010 SHALL have port: gcd_ack  input  1  acknowledge from the shared GCD unit.
REQ-011 SHALL have port: gcd_C  input  16  result from the shared GCD unit; may be Hi-Z outside its result phase.
REQ-012 SHALL have port: busy  output  1  high whenever a client holds the grant.
REQ-013 SHALL have port: grant  output  1  index of the granted client; valid only while busy=1.

Function
REQ-014 SHALL implement an FSM with states IDLE, A_PH, A_REL, B_WAIT, B_PH, DONE.
REQ-015 SHALL, in IDLE, sample req0/req1; if any is high, register the grant and go to A_PH on the next edge; gcd_req SHALL stay 0 in IDLE.
REQ-016 SHALL arbitrate round-robin: if both requests are high, grant the client not granted last; after reset, client 0 wins the first tie.
REQ-017 SHALL hold the grant for one complete transaction (A handshake plus B/result handshake), with no preemption.
REQ-018 SHALL, while busy, drive gcd_req = req[grant] and gcd_AB = AB[grant] combinationally; gcd_AB = 0 when not busy.
REQ-019 SHALL drive ack[grant] = gcd_ack while busy; the non-granted client's ack SHALL be 0.
REQ-020 SHALL drive C[grant] = gcd_C only in DONE with gcd_ack=1; otherwise C0/C1 = 0 (never Hi-Z).
REQ-021 SHALL transition A_PH -> A_REL when gcd_ack=1.
REQ-022 SHALL transition A_REL -> B_WAIT when req[grant]=0 and gcd_ack=0.
REQ-023 SHALL transition B_WAIT -> B_PH when req[grant]=1 (operand B is presented).
REQ-024 SHALL transition B_PH -> DONE when gcd_ack=1.
REQ-025 SHALL transition DONE -> IDLE when req[grant]=0, and SHALL record grant as last-granted at that point.
REQ-026 SHALL NOT grant a new client in the cycle it returns to IDLE; arbitration for the next transaction occurs one cycle later.
REQ-027 SHALL ignore all activity on the non-granted client's req/AB while busy; that client waits with ack=0.
REQ-028 SHALL return any illegal state encoding to IDLE on the next edge.
REQ-029 SHALL add no latency on the req/ack/AB/C paths while granted (purely combinational muxing).

Reset
REQ-030 SHALL, on reset=1 and asynchronously, force state=IDLE, last-granted=1 (so client 0 wins the first tie), busy=0, grant=0, gcd_req=0, gcd_AB=0, ack0=ack1=0, C0=C1=0.
REQ-031 SHALL, on reset asserted mid-transaction, abandon the transaction; the shared GCD unit is reset by the same signal, and no partial result is delivered.

Verification
REQ-032 Single client: client 0 sends A=12, B=18 -> ack0 pulses for A; later ack0=1 with C0=6; ack1=0 throughout; busy falls the cycle after req0 drops.
REQ-033 Tie: req0 and req1 rise on the same edge after reset -> client 0 is served first (GCD(48,36)=12), then client 1 (GCD(35,14)=7) with grant=1.
REQ-034 Fairness: both clients re-request continuously for 4 transactions -> grant sequence is 0,1,0,1 and each client sees correct results.
REQ-035 Contention: req1 rises during client 0's B_PH -> gcd_req/gcd_AB follow client 0 only; ack1=0 and C1=0 until client 1 is granted.
REQ-036 Mid-op reset: reset asserted in B_PH -> all outputs take their REQ-030 values immediately; a fresh transaction A=7, B=7 then returns C=7.
REQ-037 Equal-operand edge case: A=B=65535 -> C=65535 is delivered to the granted client only.
